mont_cmd_scheduler: RTL and testbench

Command sequencer inside `montgomery_wrapper` that decodes 32-bit host commands arriving on port1, drives operand loading from BRAM, starts and tracks up to `NUM_OF_CORES` Montgomery cores, and hands results back to BRAM. It reports completion and status to the host on port2. The scheduler owns only control; operand and result datapaths stay in the wrapper and cores.

---
 rtl/mont_cmd_scheduler_if.sv | 29 ++
 rtl/mont_cmd_scheduler.sv | 142 ++++++++++++++
 tb/tb_mont_cmd_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mont_cmd_scheduler_if.sv
// Control-side signal bundle between the Montgomery command scheduler and its host, BRAM and cores.
interface mont_cmd_scheduler_if #(parameter int NUM_OF_CORES = 2);
    logic [31:0]             port1_din;
    logic                    port1_valid;
    logic                    port1_read;
    logic                    port2_valid;
    logic                    port2_read;
    logic [31:0]             port2_dout;
    logic                    bram_din_valid;
    logic [NUM_OF_CORES-1:0] ld_en;
    logic [NUM_OF_CORES-1:0] core_start;
    logic [NUM_OF_CORES-1:0] core_done;
    logic                    out_capture;
    logic                    bram_dout_valid;
    logic                    bram_dout_read;
    logic                    busy;

    modport master (
        output port1_din, port1_valid, port2_read, bram_din_valid, core_done, bram_dout_read,
        input  port1_read, port2_valid, port2_dout, ld_en, core_start, out_capture,
               bram_dout_valid, busy
    );

    modport slave (
        input  port1_din, port1_valid, port2_read, bram_din_valid, core_done, bram_dout_read,
        output port1_read, port2_valid, port2_dout, ld_en, core_start, out_capture,
               bram_dout_valid, busy
    );
endinterface

// File: rtl/mont_cmd_scheduler.sv
// Decodes host commands and sequences operand load, core compute and result capture.
// state          | meaning
// IDLE           | waiting for an armed host command
// LOAD_WAIT      | READ: waiting for BRAM operands, then pulses ld_en
// START          | COMPUTE: issues core_start, clears done bits and counter
// COMPUTE_WAIT   | collecting sticky done bits from masked cores
// CAPTURE        | WRITE: issues out_capture
// WRITE_WAIT     | holding bram_dout_valid until BRAM consumes results
// RESP           | holding port2_valid until host acknowledges
module mont_cmd_scheduler #(
    parameter int NUM_OF_CORES = 2
) (
    input logic           clk,
    input logic           resetn,
    mont_cmd_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_WAIT, S_START, S_COMPUTE_WAIT, S_CAPTURE, S_WRITE_WAIT, S_RESP
    } state_t;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_COMPUTE = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;
    localparam logic [NUM_OF_CORES-1:0] ALL_CORES = '1;

    state_t                  state, state_nxt;
    logic                    armed;
    logic                    accept;
    logic [1:0]              op_in, op_q;
    logic [NUM_OF_CORES-1:0] mask_field, mask_in, mask_q;
    logic [NUM_OF_CORES-1:0] done_q, done_nxt;
    logic [15:0]             cnt_q;
    logic [1:0]              st_op;
    logic                    st_err;
    logic [NUM_OF_CORES-1:0] st_mask;
    logic [15:0]             st_cnt;
    logic                    p1_read_q, p1_read_nxt;
    logic                    cap_q, cap_nxt;
    logic [NUM_OF_CORES-1:0] ld_q, ld_nxt;
    logic [NUM_OF_CORES-1:0] start_q, start_nxt;
    logic                    unused_din;

    assign op_in      = bus.port1_din[1:0];
    assign mask_field = bus.port1_din[8 +: NUM_OF_CORES];
    assign mask_in    = (mask_field == '0) ? ALL_CORES : mask_field;
    assign accept     = (state == S_IDLE) && armed && bus.port1_valid;
    assign unused_din = ^{bus.port1_din[31:8+NUM_OF_CORES], bus.port1_din[7:2]};

    // A done arriving alongside core_start belongs to a previous run and is dropped.
    assign done_nxt = done_q | ((start_q == '0) ? (bus.core_done & mask_q) : '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_READ:    state_nxt = S_LOAD_WAIT;
                        OP_COMPUTE: state_nxt = S_START;
                        OP_WRITE:   state_nxt = S_CAPTURE;
                        default:    state_nxt = S_RESP;
                    endcase
                end
            end
            S_LOAD_WAIT:    if (ld_q != '0) state_nxt = S_RESP;
            S_START:        state_nxt = S_COMPUTE_WAIT;
            S_COMPUTE_WAIT: if (done_nxt == mask_q) state_nxt = S_RESP;
            S_CAPTURE:      state_nxt = S_WRITE_WAIT;
            S_WRITE_WAIT:   if (!cap_q && bus.bram_dout_read) state_nxt = S_RESP;
            S_RESP:         if (bus.port2_read) state_nxt = S_IDLE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy            = (state != S_IDLE);
        bus.port2_valid     = (state == S_RESP);
        bus.bram_dout_valid = (state == S_WRITE_WAIT) && !cap_q;
        p1_read_nxt         = accept;
        ld_nxt              = '0;
        start_nxt           = '0;
        cap_nxt             = (state == S_CAPTURE);
        if (state == S_LOAD_WAIT && ld_q == '0 && bus.bram_din_valid) ld_nxt = mask_q;
        if (state == S_START) start_nxt = mask_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed     <= 1'b1;
            op_q      <= '0;
            mask_q    <= '0;
            done_q    <= '0;
            cnt_q     <= '0;
            st_op     <= '0;
            st_err    <= 1'b0;
            st_mask   <= '0;
            st_cnt    <= '0;
            p1_read_q <= 1'b0;
            cap_q     <= 1'b0;
            ld_q      <= '0;
            start_q   <= '0;
        end else begin
            p1_read_q <= p1_read_nxt;
            cap_q     <= cap_nxt;
            ld_q      <= ld_nxt;
            start_q   <= start_nxt;
            if (accept)                armed <= 1'b0;
            else if (!bus.port1_valid) armed <= 1'b1;
            if (accept) begin
                op_q   <= op_in;
                mask_q <= mask_in;
            end
            if (state == S_START) begin
                done_q <= '0;
                cnt_q  <= '0;
            end else if (state == S_COMPUTE_WAIT) begin
                done_q <= done_nxt;
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
            // Illegal opcodes jump straight from IDLE, so status comes from the live command.
            if (state_nxt == S_RESP && state != S_RESP) begin
                st_op   <= (state == S_IDLE) ? op_in : op_q;
                st_err  <= (state == S_IDLE) && (op_in == OP_ILLEGAL);
                st_mask <= (state == S_IDLE) ? mask_in : mask_q;
                if (state == S_COMPUTE_WAIT) st_cnt <= cnt_q;
            end
        end
    end

    assign bus.port1_read  = p1_read_q;
    assign bus.ld_en       = ld_q;
    assign bus.core_start  = start_q;
    assign bus.out_capture = cap_q;
    assign bus.port2_dout  = {st_cnt, 8'(st_mask), 5'b0, st_err, st_op};

endmodule

// File: tb/tb_mont_cmd_scheduler.sv
// Directed bench for mont_cmd_scheduler with hand-computed expectations checked by immediate assertions.
module tb_mont_cmd_scheduler;
    logic clk;
    logic resetn;
    int   n_assert;
    int   n_fail;

    mont_cmd_scheduler_if #(.NUM_OF_CORES(2)) bus ();

    mont_cmd_scheduler #(.NUM_OF_CORES(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        resetn             = 1'b0;
        bus.port1_din      = '0;
        bus.port1_valid    = 1'b0;
        bus.port2_read     = 1'b0;
        bus.bram_din_valid = 1'b0;
        bus.core_done      = '0;
        bus.bram_dout_read = 1'b0;
        tick();
        tick();
        check("rst_busy",        bus.busy, 0);
        check("rst_port2_valid", bus.port2_valid, 0);
        check("rst_port1_read",  bus.port1_read, 0);
        check("rst_dout",        bus.port2_dout, 0);
        check("rst_bram_dout_v", bus.bram_dout_valid, 0);
        resetn = 1'b1;
        tick();

        // READ, all cores
        bus.port1_din = 32'h0; bus.port1_valid = 1'b1;
        tick();
        check("rd_port1_read", bus.port1_read, 1);
        check("rd_busy",       bus.busy, 1);
        bus.port1_valid = 1'b0; bus.bram_din_valid = 1'b1;
        tick();
        check("rd_port1_read_off", bus.port1_read, 0);
        check("rd_ld_en",          bus.ld_en, 2'b11);
        check("rd_p2v_early",      bus.port2_valid, 0);
        bus.bram_din_valid = 1'b0;
        tick();
        check("rd_ld_en_off", bus.ld_en, 0);
        check("rd_p2v",       bus.port2_valid, 1);
        check("rd_dout",      bus.port2_dout, 32'h0000_0300);
        bus.port2_read = 1'b1;
        tick();
        bus.port2_read = 1'b0;
        check("rd_p2v_off", bus.port2_valid, 0);
        check("rd_idle",    bus.busy, 0);

        // COMPUTE, all cores, dones at +40 and +55
        bus.port1_din = 32'h1; bus.port1_valid = 1'b1;
        tick();
        check("cp_port1_read", bus.port1_read, 1);
        check("cp_start_early", bus.core_start, 0);
        bus.port1_valid = 1'b0;
        tick();
        check("cp_core_start", bus.core_start, 2'b11);
        bus.core_done = 2'b11;
        tick();
        check("cp_start_single", bus.core_start, 0);
        check("cp_done_with_start_ignored", bus.port2_valid, 0);
        for (int c = 1; c <= 55; c++) begin
            bus.core_done = (c == 40) ? 2'b01 : (c == 55) ? 2'b10 : 2'b00;
            if (c == 55) check("cp_p2v_before_last", bus.port2_valid, 0);
            tick();
        end
        bus.core_done = '0;
        check("cp_p2v",  bus.port2_valid, 1);
        check("cp_dout", bus.port2_dout, 32'h0037_0301);
        bus.port2_read = 1'b1;
        tick();
        bus.port2_read = 1'b0;
        check("cp_p2v_off", bus.port2_valid, 0);

        // COMPUTE, core 0 only
        bus.port1_din = 32'h101; bus.port1_valid = 1'b1;
        tick();
        bus.port1_valid = 1'b0;
        tick();
        check("m0_core_start", bus.core_start, 2'b01);
        tick();
        bus.core_done = 2'b10;
        tick();
        check("m0_unmasked_ignored", bus.port2_valid, 0);
        bus.core_done = 2'b01;
        tick();
        bus.core_done = '0;
        check("m0_p2v",  bus.port2_valid, 1);
        check("m0_dout", bus.port2_dout, 32'h0002_0101);
        bus.port2_read = 1'b1;
        tick();
        bus.port2_read = 1'b0;

        // WRITE with 5-cycle delayed bram_dout_read
        bus.port1_din = 32'h2; bus.port1_valid = 1'b1;
        tick();
        check("wr_port1_read", bus.port1_read, 1);
        check("wr_cap_early",  bus.out_capture, 0);
        bus.port1_valid = 1'b0;
        tick();
        check("wr_out_capture", bus.out_capture, 1);
        check("wr_bdv_early",   bus.bram_dout_valid, 0);
        tick();
        check("wr_cap_off", bus.out_capture, 0);
        check("wr_bdv_1",   bus.bram_dout_valid, 1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("wr_bdv_held", bus.bram_dout_valid, 1);
        end
        check("wr_p2v_early", bus.port2_valid, 0);
        bus.bram_dout_read = 1'b1;
        tick();
        bus.bram_dout_read = 1'b0;
        check("wr_bdv_off", bus.bram_dout_valid, 0);
        check("wr_p2v",     bus.port2_valid, 1);
        check("wr_dout",    bus.port2_dout, 32'h0002_0302);
        bus.port2_read = 1'b1;
        tick();
        bus.port2_read = 1'b0;

        // Illegal opcode, port1_valid held throughout
        bus.port1_din = 32'h3; bus.port1_valid = 1'b1;
        tick();
        check("il_port1_read", bus.port1_read, 1);
        check("il_p2v",        bus.port2_valid, 1);
        check("il_dout",       bus.port2_dout, 32'h0002_0307);
        check("il_pulses",     {bus.ld_en, bus.core_start, bus.out_capture}, 0);
        tick();
        check("il_read_single", bus.port1_read, 0);
        check("il_pulses2",     {bus.ld_en, bus.core_start, bus.out_capture}, 0);
        bus.port2_read = 1'b1;
        tick();
        bus.port2_read = 1'b0;
        check("il_p2v_off", bus.port2_valid, 0);
        tick();
        tick();
        check("il_no_reaccept", bus.port1_read, 0);
        check("il_stay_idle",   bus.busy, 0);
        bus.port1_valid = 1'b0;
        tick();

        // Reset during COMPUTE_WAIT
        bus.port1_din = 32'h1; bus.port1_valid = 1'b1;
        tick();
        bus.port1_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("rs_busy_before", bus.busy, 1);
        resetn = 1'b0;
        #1;
        check("rs_busy",  bus.busy, 0);
        check("rs_start", bus.core_start, 0);
        check("rs_p2v",   bus.port2_valid, 0);
        check("rs_dout",  bus.port2_dout, 0);
        tick();
        resetn = 1'b1;
        tick();
        bus.port1_din = 32'h1; bus.port1_valid = 1'b1;
        tick();
        check("rs_port1_read", bus.port1_read, 1);
        bus.port1_valid = 1'b0;
        tick();
        check("rs_core_start", bus.core_start, 2'b11);
        tick();
        bus.core_done = 2'b11;
        tick();
        bus.core_done = '0;
        check("rs_p2v_after", bus.port2_valid, 1);
        check("rs_dout_after", bus.port2_dout, 32'h0001_0301);
        bus.port2_read = 1'b1;
        tick();
        bus.port2_read = 1'b0;

        // READ, core 1 only; count must be retained
        bus.port1_din = 32'h200; bus.port1_valid = 1'b1;
        tick();
        bus.port1_valid = 1'b0;
        tick();
        check("r1_ld_wait", bus.ld_en, 0);
        bus.bram_din_valid = 1'b1;
        tick();
        bus.bram_din_valid = 1'b0;
        check("r1_ld_en",     bus.ld_en, 2'b10);
        check("r1_p2v_early", bus.port2_valid, 0);
        tick();
        check("r1_p2v",  bus.port2_valid, 1);
        check("r1_dout", bus.port2_dout, 32'h0001_0200);
        bus.port2_read = 1'b1;
        tick();
        bus.port2_read = 1'b0;
        check("r1_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
